// File: rtl/ysyx_23060136_ifu_fetch_pkg.sv
// Shared constants, state encoding and PC helpers for the instruction fetch stage.
package ysyx_23060136_ifu_fetch_pkg;

   localparam int unsigned BITS_W = 32;

   localparam logic [BITS_W-1:0] RESET_PC = 32'h8000_0000;
   localparam logic [BITS_W-1:0] NOP_INST = 32'h0000_0013;
   localparam logic [BITS_W-1:0] PC_STEP  = BITS_W'(4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } fetch_state_t;

   // Word-align a redirect target; low two bits are dropped.
   function automatic logic [BITS_W-1:0] align_pc(input logic [BITS_W-1:0] addr);
      return addr & ~BITS_W'(3);
   endfunction

endpackage

// File: rtl/ysyx_23060136_ifu_fetch.sv
// Instruction fetch: owns the fetch PC, issues one read at a time and hands
// the fetched word to IF/ID. Branch redirects squash any in-flight fetch.
module ysyx_23060136_ifu_fetch
   import ysyx_23060136_ifu_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              PCSrc,
   input  logic [BITS_W-1:0] branch_target,
   output logic [BITS_W-1:0] IFU_araddr,
   output logic              IFU_arvalid,
   input  logic              IFU_arready,
   input  logic [BITS_W-1:0] IFU_rdata,
   input  logic [1:0]        IFU_rresp,
   input  logic              IFU_rvalid,
   output logic              IFU_rready,
   output logic              IFU_valid,
   input  logic              IDU_ready,
   output logic [BITS_W-1:0] IFU_pc,
   output logic [BITS_W-1:0] IFU_inst,
   output logic              IFU_fault
);

   fetch_state_t      state;
   logic [BITS_W-1:0] fetch_pc;
   logic [BITS_W-1:0] redir_pc;
   logic              discard;

   // The request address is the fetch PC register itself, so it cannot move
   // while a request is pending (fetch_pc only changes outside S_REQ).
   assign IFU_araddr = fetch_pc;

   // Fetch FSM with registered handshake outputs and the held instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         fetch_pc    <= RESET_PC;
         redir_pc    <= RESET_PC;
         discard     <= 1'b0;
         IFU_arvalid <= 1'b0;
         IFU_rready  <= 1'b0;
         IFU_valid   <= 1'b0;
         IFU_pc      <= RESET_PC;
         IFU_inst    <= NOP_INST;
         IFU_fault   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (PCSrc) fetch_pc <= align_pc(branch_target);
               state       <= S_REQ;
               IFU_arvalid <= 1'b1;
            end

            S_REQ: begin
               // Request cannot be withdrawn; remember the redirect instead.
               if (PCSrc) begin
                  discard  <= 1'b1;
                  redir_pc <= align_pc(branch_target);
               end
               if (IFU_arready) begin
                  state       <= S_WAIT;
                  IFU_arvalid <= 1'b0;
                  IFU_rready  <= 1'b1;
               end
            end

            S_WAIT: begin
               if (IFU_rvalid) begin
                  IFU_rready <= 1'b0;
                  if (discard || PCSrc) begin
                     // Wrong-path data: drop it and restart at the newest target.
                     discard     <= 1'b0;
                     fetch_pc    <= PCSrc ? align_pc(branch_target) : redir_pc;
                     state       <= S_REQ;
                     IFU_arvalid <= 1'b1;
                  end else begin
                     IFU_pc      <= fetch_pc;
                     IFU_inst    <= (IFU_rresp != 2'b00) ? NOP_INST : IFU_rdata;
                     IFU_fault   <= (IFU_rresp != 2'b00);
                     state       <= S_VALID;
                     IFU_valid   <= 1'b1;
                  end
               end else if (PCSrc) begin
                  discard  <= 1'b1;
                  redir_pc <= align_pc(branch_target);
               end
            end

            S_VALID: begin
               // Redirect wins over a same-cycle handoff to IF/ID.
               if (PCSrc) begin
                  fetch_pc    <= align_pc(branch_target);
                  state       <= S_REQ;
                  IFU_valid   <= 1'b0;
                  IFU_arvalid <= 1'b1;
               end else if (IDU_ready) begin
                  fetch_pc    <= fetch_pc + PC_STEP;
                  state       <= S_REQ;
                  IFU_valid   <= 1'b0;
                  IFU_arvalid <= 1'b1;
               end
            end

            default: begin
               state       <= S_IDLE;
               IFU_arvalid <= 1'b0;
               IFU_rready  <= 1'b0;
               IFU_valid   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch.sv
// Bench for the fetch stage: directed reset/stall/reset-in-flight checks, then
// random memory latency, error responses, stalls and redirects against a
// program-order model held in a scoreboard queue.
module tb_ysyx_23060136_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PCSrc;
   logic [31:0] branch_target;
   logic [31:0] IFU_araddr;
   logic        IFU_arvalid;
   logic        IFU_arready;
   logic [31:0] IFU_rdata;
   logic [1:0]  IFU_rresp;
   logic        IFU_rvalid;
   logic        IFU_rready;
   logic        IFU_valid;
   logic        IDU_ready;
   logic [31:0] IFU_pc;
   logic [31:0] IFU_inst;
   logic        IFU_fault;

   int tests  = 0;
   int failed = 0;

   logic        mem_auto = 1'b0;
   logic        mon_en   = 1'b0;
   logic [31:0] exp_q[$];

   ysyx_23060136_ifu_fetch dut (
      .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .branch_target(branch_target),
      .IFU_araddr(IFU_araddr), .IFU_arvalid(IFU_arvalid), .IFU_arready(IFU_arready),
      .IFU_rdata(IFU_rdata), .IFU_rresp(IFU_rresp), .IFU_rvalid(IFU_rvalid),
      .IFU_rready(IFU_rready), .IFU_valid(IFU_valid), .IDU_ready(IDU_ready),
      .IFU_pc(IFU_pc), .IFU_inst(IFU_inst), .IFU_fault(IFU_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return (a[5:2] == 4'hB) || (a == 32'h0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory slave: one outstanding read, random accept and data latency.
   initial begin : mem_proc
      logic        ar_hs, r_hs, pending;
      logic [31:0] hs_addr, paddr;
      int          lat;
      pending = 1'b0;
      lat     = 0;
      paddr   = '0;
      forever begin
         @(negedge clk);
         ar_hs   = IFU_arvalid && IFU_arready;
         r_hs    = IFU_rvalid && IFU_rready;
         hs_addr = IFU_araddr;
         @(posedge clk);
         #1;
         if (mem_auto) begin
            if (!rst_n) begin
               pending     = 1'b0;
               IFU_rvalid  = 1'b0;
               IFU_arready = 1'b0;
            end else begin
               if (r_hs) begin
                  IFU_rvalid = 1'b0;
                  pending    = 1'b0;
               end
               if (ar_hs) begin
                  pending = 1'b1;
                  paddr   = hs_addr;
                  lat     = $urandom_range(0, 3);
               end
               if (pending && !IFU_rvalid) begin
                  if (lat == 0) begin
                     IFU_rvalid = 1'b1;
                     IFU_rdata  = mem_word(paddr);
                     IFU_rresp  = mem_err(paddr) ? 2'($urandom_range(2, 3)) : 2'b00;
                  end else begin
                     lat--;
                  end
               end
               IFU_arready = !pending && ($urandom_range(0, 2) != 0);
            end
         end
      end
   end

   // Monitor: every instruction handed to IF/ID is checked against the model.
   initial begin : monitor
      logic        prev_wait_ar;
      logic [31:0] prev_addr, e;
      int          idle;
      prev_wait_ar = 1'b0;
      prev_addr    = '0;
      idle         = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (prev_wait_ar) begin
               check("arvalid_hold", 32'(IFU_arvalid), 32'd1);
               check("araddr_stable", IFU_araddr, prev_addr);
            end
            prev_wait_ar = IFU_arvalid && !IFU_arready;
            prev_addr    = IFU_araddr;
            if (!PCSrc && IFU_valid && IDU_ready) begin
               idle = 0;
               if (exp_q.size() == 0) begin
                  tests++;
                  failed++;
                  $display("FAIL unexpected_inst: got pc %h expected none", IFU_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("deliver_pc", IFU_pc, e);
                  check("deliver_inst", IFU_inst, mem_err(e) ? NOP : mem_word(e));
                  check("deliver_fault", 32'(IFU_fault), 32'(mem_err(e)));
                  exp_q.push_back(e + 32'd4);
               end
            end else begin
               idle++;
               if (idle > 300) begin
                  tests++;
                  failed++;
                  $display("FAIL progress_timeout: got no delivery in %0d cycles expected one", idle);
                  idle = 0;
               end
            end
         end else begin
            prev_wait_ar = 1'b0;
         end
      end
   end

   // Stimulus: directed sequences, then randomized redirects and stalls.
   initial begin : stim
      logic [31:0] tgt;
      rst_n = 1'b0; PCSrc = 1'b0; branch_target = '0; IDU_ready = 1'b0;
      IFU_arready = 1'b0; IFU_rvalid = 1'b0; IFU_rdata = '0; IFU_rresp = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_arvalid", 32'(IFU_arvalid), 32'd0);
      check("rst_rready", 32'(IFU_rready), 32'd0);
      check("rst_valid", 32'(IFU_valid), 32'd0);
      check("rst_pc", IFU_pc, RST_PC);
      check("rst_inst", IFU_inst, NOP);
      check("rst_fault", 32'(IFU_fault), 32'd0);
      check("rst_araddr", IFU_araddr, RST_PC);

      // Cycle 1: reset released, still idle.
      rst_n = 1'b1;
      IFU_arready = 1'b1;
      check("c1_arvalid", 32'(IFU_arvalid), 32'd0);
      tick();
      check("c2_arvalid", 32'(IFU_arvalid), 32'd1);
      check("c2_araddr", IFU_araddr, RST_PC);
      tick();
      IFU_arready = 1'b0;
      check("c3_arvalid", 32'(IFU_arvalid), 32'd0);
      check("c3_rready", 32'(IFU_rready), 32'd1);
      check("c3_valid", 32'(IFU_valid), 32'd0);
      IFU_rvalid = 1'b1; IFU_rdata = 32'h0000_0093; IFU_rresp = 2'b00;
      tick();
      IFU_rvalid = 1'b0;
      check("c4_valid", 32'(IFU_valid), 32'd1);
      check("c4_pc", IFU_pc, RST_PC);
      check("c4_inst", IFU_inst, 32'h0000_0093);
      check("c4_fault", 32'(IFU_fault), 32'd0);

      // Downstream stall holds the instruction and issues nothing.
      IDU_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", 32'(IFU_valid), 32'd1);
         check("stall_arvalid", 32'(IFU_arvalid), 32'd0);
      end
      check("stall_pc", IFU_pc, RST_PC);
      check("stall_inst", IFU_inst, 32'h0000_0093);
      IDU_ready = 1'b1;
      tick();
      IDU_ready = 1'b0;
      check("next_arvalid", 32'(IFU_arvalid), 32'd1);
      check("next_araddr", IFU_araddr, RST_PC + 32'd4);
      check("next_valid", 32'(IFU_valid), 32'd0);

      // Reset asserted while waiting for read data.
      IFU_arready = 1'b1;
      tick();
      IFU_arready = 1'b0;
      check("wait_rready", 32'(IFU_rready), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_arvalid", 32'(IFU_arvalid), 32'd0);
      check("arst_rready", 32'(IFU_rready), 32'd0);
      check("arst_valid", 32'(IFU_valid), 32'd0);
      check("arst_inst", IFU_inst, NOP);
      check("arst_araddr", IFU_araddr, RST_PC);
      IFU_rvalid = 1'b1; IFU_rdata = 32'hDEAD_BEEF;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("late_arvalid", 32'(IFU_arvalid), 32'd1);
      check("late_araddr", IFU_araddr, RST_PC);
      check("late_rready", 32'(IFU_rready), 32'd0);
      tick();
      check("late_valid", 32'(IFU_valid), 32'd0);
      check("late_arvalid2", 32'(IFU_arvalid), 32'd1);
      IFU_rvalid = 1'b0;

      // Randomized phase against the program-order model.
      rst_n = 1'b0;
      mem_auto = 1'b1;
      tick();
      exp_q.delete();
      exp_q.push_back(RST_PC);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         tick();
         IDU_ready = ($urandom_range(0, 3) != 0);
         PCSrc     = ($urandom_range(0, 9) == 0);
         if (PCSrc) begin
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF4;
            else tgt = RST_PC + 32'($urandom_range(0, 63) * 4);
            branch_target = tgt | 32'($urandom_range(0, 3));
            exp_q.delete();
            exp_q.push_back(tgt);
         end else begin
            branch_target = 32'($urandom);
         end
      end
      PCSrc = 1'b0;
      tick();
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
